// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master = operand producer and result consumer; slave = the adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder, one CHUNK-bit slice per stage.
// Latency STAGES cycles of occupancy; one result per cycle at full rate.
// Backpressure: bubble-collapsing stall; in_ready drops only when all stages hold results.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave io
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];

    // What each stage would load: previous stage's registers, or the inputs for stage 0.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];

    logic [STAGES-1:0] nxt_c;
    logic [WIDTH-1:0]  nxt_s [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_first
            assign src_v[k] = io.in_valid;
            assign src_c[k] = io.cin;
            assign src_s[k] = '0;
            assign src_a[k] = io.a;
            assign src_b[k] = io.b;
        end else begin : g_rest
            assign src_v[k] = v[k-1];
            assign src_c[k] = c_q[k-1];
            assign src_s[k] = s_q[k-1];
            assign src_a[k] = a_q[k-1];
            assign src_b[k] = b_q[k-1];
        end
    end

    // Stage k may advance if it, or any stage after it, is empty, or the consumer takes the head.
    always_comb begin
        logic all_v;
        all_v = 1'b1;
        en    = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_v = all_v & v[k];
            en[k] = !all_v || io.out_ready;
        end
    end

    always_comb begin
        logic c;
        logic x;
        logic y;
        c = 1'b0;
        x = 1'b0;
        y = 1'b0;
        nxt_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            nxt_s[k] = src_s[k];
            c        = src_c[k];
            for (int i = 0; i < CHUNK; i++) begin
                x = src_a[k][k*CHUNK + i];
                y = src_b[k][k*CHUNK + i];
                nxt_s[k][k*CHUNK + i] = x ^ y ^ c;
                c = (x & y) | (y & c) | (c & x);
            end
            nxt_c[k] = c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v   <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    v[k]   <= src_v[k];
                    c_q[k] <= nxt_c[k];
                    s_q[k] <= nxt_s[k];
                    a_q[k] <= src_a[k];
                    b_q[k] <= src_b[k];
                end
            end
        end
    end

    assign io.in_ready  = en[0];
    assign io.out_valid = v[STAGES-1];
    assign io.sum       = s_q[STAGES-1];
    assign io.cout      = c_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: a 16-bit/4-stage and a 3-bit/3-stage adder against a queue-based model.
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(16)) w16 ();
    pipelined_adder_if #(.WIDTH(3))  w3 ();

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut16 (.clk(clk), .rst(rst), .io(w16.slave));
    pipelined_adder #(.WIDTH(3),  .STAGES(3)) dut3  (.clk(clk), .rst(rst), .io(w3.slave));

    typedef struct {
        logic [16:0] res;
        int          acc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    exp_t q16[$];
    exp_t q3[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // One clock cycle on DUT d (0: 16-bit, 1: 3-bit). Model: in-flight results in acceptance
    // order; the oldest is presented once STAGES-1 edges have passed since it was accepted.
    task automatic step(input int d, input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic ordy, input logic r,
                        output logic o_acc, output logic o_out, output logic o_v,
                        output logic [16:0] o_res);
        logic ir, ov, exp_ir, exp_ov;
        logic [16:0] res;
        int s, size;
        exp_t fr;
        fr.res = '0;
        fr.acc = 0;
        rst = r;
        w16.in_valid  = (d == 0) && iv;
        w16.a         = ia;
        w16.b         = ib;
        w16.cin       = ic;
        w16.out_ready = (d == 0) ? ordy : 1'b1;
        w3.in_valid   = (d == 1) && iv;
        w3.a          = ia[2:0];
        w3.b          = ib[2:0];
        w3.cin        = ic;
        w3.out_ready  = (d == 1) ? ordy : 1'b1;
        #4;
        if (d == 0) begin
            ir = w16.in_ready; ov = w16.out_valid; res = {w16.cout, w16.sum}; s = 4;
            size = q16.size();
            if (size > 0) fr = q16[0];
        end else begin
            ir = w3.in_ready; ov = w3.out_valid; res = {13'b0, w3.cout, w3.sum}; s = 3;
            size = q3.size();
            if (size > 0) fr = q3[0];
        end
        o_v = ov; o_res = res; o_acc = 1'b0; o_out = 1'b0;
        if (r) begin
            q16.delete();
            q3.delete();
        end else begin
            exp_ir = (size < s) || ordy;
            exp_ov = (size > 0) && (cyc >= fr.acc + s - 1);
            check(d == 0 ? "in_ready16" : "in_ready3", 32'(ir), 32'(exp_ir));
            check(d == 0 ? "out_valid16" : "out_valid3", 32'(ov), 32'(exp_ov));
            if (exp_ov) check(d == 0 ? "result16" : "result3", 32'(res), 32'(fr.res));
            if (exp_ov && ordy) begin
                o_out = 1'b1;
                if (d == 0) void'(q16.pop_front()); else void'(q3.pop_front());
            end
            if (iv && exp_ir) begin
                o_acc = 1'b1;
                if (d == 0) begin
                    fr.res = 17'(ia) + 17'(ib) + 17'(ic);
                    fr.acc = cyc + 1;
                    q16.push_back(fr);
                end else begin
                    fr.res = 17'(ia[2:0]) + 17'(ib[2:0]) + 17'(ic);
                    fr.acc = cyc + 1;
                    q3.push_back(fr);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_checks();
        check("rst_out_valid16", 32'(w16.out_valid), 32'd0);
        check("rst_sum16", 32'(w16.sum), 32'd0);
        check("rst_cout16", 32'(w16.cout), 32'd0);
        check("rst_in_ready16", 32'(w16.in_ready), 32'd1);
        check("rst_out_valid3", 32'(w3.out_valid), 32'd0);
        check("rst_in_ready3", 32'(w3.in_ready), 32'd1);
    endtask

    initial begin
        vec_t vt[7];
        logic acc, outx, ov, seen;
        logic [16:0] res, held;
        int n, cnt, nout, idx, guard;
        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vt[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vt[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vt[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vt[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vt[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

        step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, acc, outx, ov, res);
        step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, acc, outx, ov, res);
        reset_checks();

        // Directed vectors, one at a time, with fixed latency and a single-cycle result pulse.
        for (int i = 0; i < 7; i++) begin
            step(0, 1'b1, vt[i].a, vt[i].b, vt[i].cin, 1'b1, 1'b0, acc, outx, ov, res);
            seen = 1'b0;
            n = 0;
            while (!seen && n < 10) begin
                step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc, outx, ov, res);
                n++;
                if (ov) seen = 1'b1;
            end
            check("vec_seen", 32'(seen), 32'd1);
            check("vec_latency", 32'(n), 32'd4);
            check("vec_result", 32'(res), {15'b0, vt[i].cout, vt[i].sum});
            step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc, outx, ov, res);
            check("vec_pulse", 32'(ov), 32'd0);
        end

        // Back-to-back stream at full rate.
        cnt = 0; nout = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0, acc, outx, ov, res);
            cnt += int'(acc); nout += int'(outx);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc, outx, ov, res);
            nout += int'(outx);
        end
        check("stream_accepted", 32'(cnt), 32'd16);
        check("stream_delivered", 32'(nout), 32'd16);

        // Stall: only STAGES operands fit, and the head result stays frozen.
        cnt = 0; nout = 0; seen = 1'b0; held = '0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0, acc, outx, ov, res);
            cnt += int'(acc);
            if (ov && !seen) begin seen = 1'b1; held = res; end
            else if (ov) check("stall_frozen", 32'(res), 32'(held));
        end
        check("stall_accepted", 32'(cnt), 32'd4);
        check("stall_in_ready", 32'(w16.in_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc, outx, ov, res);
            nout += int'(outx);
        end
        check("stall_delivered", 32'(nout), 32'd4);

        // Gapped input under stall: bubbles are squeezed out before in_ready drops.
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1'(i % 2 == 0), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0,
                 acc, outx, ov, res);
            cnt += int'(acc);
        end
        check("bubble_accepted", 32'(cnt), 32'd4);
        for (int i = 0; i < 8; i++)
            step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc, outx, ov, res);

        // Reset with three operations in flight and a transfer offered during reset.
        for (int i = 0; i < 3; i++)
            step(0, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b0, acc, outx, ov, res);
        step(0, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b1, acc, outx, ov, res);
        reset_checks();
        nout = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc, outx, ov, res);
            nout += int'(ov);
        end
        check("rst_no_stale", 32'(nout), 32'd0);

        // Random traffic on both sides.
        for (int i = 0; i < 300; i++)
            step(0, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                 1'b0, acc, outx, ov, res);
        for (int i = 0; i < 8; i++)
            step(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc, outx, ov, res);

        // Exhaustive 3-bit, one bit per stage, random consumer stalls.
        idx = 0; guard = 0; nout = 0;
        while (idx < 128 && guard < 3000) begin
            step(1, 1'b1, 16'((idx >> 4) & 7), 16'((idx >> 1) & 7), 1'(idx & 1),
                 1'($urandom_range(0, 1)), 1'b0, acc, outx, ov, res);
            idx += int'(acc); nout += int'(outx); guard++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc, outx, ov, res);
            nout += int'(outx);
        end
        check("exh_accepted", 32'(idx), 32'd128);
        check("exh_delivered", 32'(nout), 32'd128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder that generalises the single-bit full adder to WIDTH-bit operands split into STAGES registered chunks. Each stage adds one CHUNK-bit slice and passes its carry to the next stage. A valid/ready handshake on both sides gives one result per cycle at full throughput, with lossless backpressure. The block is the datapath adder for wider arithmetic units and sits between operand-producing logic and any result consumer that may stall.

## Interface
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); CHUNK = WIDTH/STAGES bits added per stage.
- clk  input  1  rising-edge clock; one clock domain.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operands a, b, cin are valid this cycle.
- in_ready  output  1  block accepts operands this cycle; a transfer occurs when in_valid && in_ready.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer accepts the result; a transfer occurs when out_valid && out_ready.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- Stage k (0..STAGES-1) holds:
  - a valid bit v[k];
  - the completed low sum bits [(k+1)*CHUNK-1:0];
  - the carry out of chunk k;
  - the still-unadded upper slices of a and b.
- Stage 0 computes chunk 0 = a[CHUNK-1:0] + b[CHUNK-1:0] + cin.
- Stage k > 0 computes chunk k from its registered operand slices and the registered carry of stage k-1.
- Each bit-slice add is the full-adder equations per bit:
  - s = x ^ y ^ c;
  - co = x&y | y&c | c&x.
- The last stage drives sum, cout and out_valid directly from its registers.
- Per-stage advance (bubble-collapsing):
  - en[STAGES-1] = !v[STAGES-1] || out_ready;
  - en[k] = !v[k] || en[k+1].
- in_ready = en[0]. It is combinational from out_ready and the valid bits only; there is no path from in_valid.
- When en[k] is high, stage k loads the output of stage k-1, or the inputs for k = 0, along with its valid bit. When en[k] is low, stage k holds.
- Results leave in acceptance order. None are dropped or duplicated.
- STAGES = 1: a single registered WIDTH-bit add with the same handshake.
- Width rules:
  - all arithmetic is unsigned;
  - the internal carry between stages is 1 bit;
  - sum wraps modulo 2^WIDTH and the overflow appears only on cout.

## Timing
- Reset (rst high at a clock edge):
  - all v[k] = 0, out_valid = 0, sum = 0, cout = 0 on the next cycle;
  - in_ready = 1 from the first cycle after reset;
  - any in-flight operations are discarded, with no partial result emitted;
  - rst has priority over a simultaneous in_valid transfer, and that transfer is lost.
- Latency: operands accepted at edge n give out_valid = 1 after edge n+STAGES-1, i.e. STAGES cycles of occupancy.
- Throughput: one transfer per cycle while out_ready stays high.
- Backpressure: while out_valid && !out_ready, sum and cout stay stable and unchanged.
- Capacity: the pipeline holds at most STAGES results. in_ready falls only when every stage is valid and out_ready is low.
- Full pipeline with out_ready high: an input and an output transfer may occur in the same cycle, and in_ready stays high.
- Bubbles: a gap in in_valid creates an invalid stage. When downstream stalls, the bubble is overwritten, so in_ready stays high until all stages are full.

## Test plan
- Carry across all chunks (WIDTH=16, STAGES=4): a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> 4 cycles later sum=0x0000, cout=1, out_valid high for exactly 1 cycle.
- Simple add: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. Then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1.
- Streaming: 16 back-to-back random vectors with out_ready=1 -> 16 results on consecutive cycles in order, each equal to {cout,sum} = a+b+cin, and in_ready held at 1.
- Backpressure: stream with out_ready=0 for 6 cycles -> exactly 4 accepted, in_ready=0 afterwards, sum/cout frozen. Then out_ready=1 -> all 4 results delivered in order with none lost, and in_ready rises in the same cycle.
- Reset mid-operation: 3 operations in flight, rst=1 for 1 cycle -> next cycle out_valid=0, sum=0, cout=0, in_ready=1, and no stale result ever appears afterwards.
- Exhaustive small config (WIDTH=3, STAGES=3, CHUNK=1): all 128 {a,b,cin} combinations streamed with random out_ready -> every result equals a+b+cin (4-bit), in order.
